// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four requesters share one 3-bit lane through a 4:1 mux.
// The arbiter picks a winner round-robin and hands its data downstream with
// a valid/ready handshake. The winner gets a one-cycle ack after its transfer.
// A watchdog releases a grant that has stalled.
// Optional build macro: MUX_ARB_LOCK_EN adds a 'lock' input. With lock held,
// the owner keeps the lane for back-to-back transfers.
module mux4_rr_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [2:0] in0,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  input  logic       out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic [2:0] out0,
  output logic [3:0] ack,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic       xfer;
  logic       hold;

  // Round-robin pick: the first set request after ptr wins. The loop runs
  // from the farthest slot to the nearest, so the nearest match is the last
  // one written.
  always_comb begin
    win = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
  end

  assign xfer = (state_q == GRANT) && out_ready;

`ifdef MUX_ARB_LOCK_EN
  assign hold = lock && req[sel_q];
`else
  assign hold = 1'b0;
`endif

  // Next-state logic. In GRANT, priority is: transfer, then abort (the owner
  // dropped req), then the watchdog.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req != 4'b0000) begin
          sel_d   = win;
          grant_d = 4'b0001 << win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          ack_d = grant_q;
          cnt_d = '0;
          if (!hold) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = sel_q;
          end
        end else if (!req[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // The stalled owner gives up priority, just as after a real transfer.
          timeout_d = 1'b1;
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = sel_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers. After reset, ptr=3, so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      ack_q     <= 4'b0000;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Datapath mux. It follows the live inputs so the owner's data reaches the
  // consumer with no register in the path.
  always_comb begin
    case (sel_q)
      2'd0:    out0 = in0;
      2'd1:    out0 = in1;
      2'd2:    out0 = in2;
      default: out0 = in3;
    endcase
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = (grant_q != 4'b0000);
  assign ack       = ack_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. A negedge monitor keeps a scoreboard
// of expected transfers (requester, data). Each expected transfer is pushed
// when its stimulus is driven. It is checked against the data on the
// handshake and popped when its ack appears.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [2:0] in0, in1, in2, in3;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
  logic [2:0] out0;
  logic [3:0] ack;
  logic       timeout;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  typedef struct {
    logic [1:0] idx;
    logic [2:0] data;
  } exp_t;
  exp_t sbq[$];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  mux4_rr_arbiter #(.MAX_WAIT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_ready(out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .sel(sel), .grant(grant), .out_valid(out_valid), .out0(out0),
    .ack(ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the posedge plus 1, so a check right after tick sees the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] din(input int i);
    case (i)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  task automatic push(input int i);
    exp_t e;
    e.idx  = 2'(i);
    e.data = din(i);
    sbq.push_back(e);
  endtask

  // Scoreboard monitor. An ack retires the oldest expected transfer. A
  // handshake is checked against the transfer that is then the oldest.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ack != 4'b0000) begin
        if (sbq.size() == 0) begin
          total++; failed++;
          $error("FAIL sb_ack: observed ack %b expected none", ack);
        end else begin
          e = sbq.pop_front();
          chk("sb_ack", 32'(ack), 32'(1) << e.idx);
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; failed++;
          $error("FAIL sb_xfer: observed transfer sel=%0d expected none", sel);
        end else begin
          chk("sb_sel", 32'(sel), 32'(sbq[0].idx));
          chk("sb_data", 32'(out0), 32'(sbq[0].data));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    in0 = 3'b101; in1 = 3'b011; in2 = 3'b110; in3 = 3'b001;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out0", 32'(out0), 32'(3'b101));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single transfer from requester 0: a grant after 1 cycle, an ack after 2.
    req = 4'b0001; out_ready = 1'b1; push(0);
    tick();
    chk("t1_sel", 32'(sel), 0);
    chk("t1_grant", 32'(grant), 1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_out0", 32'(out0), 32'(3'b101));
    tick();
    chk("t1_ack", 32'(ack), 1);
    chk("t1_idle", 32'(grant), 0);
    req = 4'b0000;
    tick();
    chk("t1_ack_clr", 32'(ack), 0);

    // All four requesting: service order 0,1,2,3,0, with a bubble between each.
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(i % 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1) << (i % 4));
      chk("rr_out0", 32'(out0), 32'(din(i % 4)));
      tick();
      chk("rr_ack", 32'(ack), 32'(1) << (i % 4));
      chk("rr_bubble", 32'(grant), 0);
    end
    req = 4'b0000;
    tick();

    // Set ptr=1 with a transfer from requester 1. Then 0110 picks 2 first, then 1.
    req = 4'b0010; push(1);
    tick(); tick();
    req = 4'b0000;
    tick();
    req = 4'b0110; push(2); push(1);
    tick();
    chk("p1_sel", 32'(sel), 2);
    chk("p1_out0", 32'(out0), 32'(3'b110));
    tick();
    chk("p1_ack", 32'(ack), 32'(4'b0100));
    req = 4'b0010;
    tick();
    chk("p1_sel2", 32'(sel), 1);
    tick();
    chk("p1_ack2", 32'(ack), 32'(4'b0010));
    req = 4'b0000;
    tick();

    // Watchdog: 15 stalled grant cycles, then a timeout pulse in cycle 16.
    req = 4'b1000; out_ready = 1'b0;
    tick();
    chk("wd_grant", 32'(grant), 32'(4'b1000));
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk("wd_hold", 32'({timeout, grant}), 32'(5'b01000));
    end
    tick();
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_grant0", 32'(grant), 0);
    chk("wd_noack", 32'(ack), 0);
    chk("wd_valid0", 32'(out_valid), 0);
    req = 4'b1001; out_ready = 1'b1; push(0);
    tick();
    chk("wd_pulse", 32'(timeout), 0);
    chk("wd_prio", 32'(grant), 1);
    tick();
    chk("wd_ack0", 32'(ack), 1);
    req = 4'b0000;
    tick();

    // Abort: requester 1 drops its req while stalled. ptr stays put, so 1 wins again.
    req = 4'b0110; out_ready = 1'b0;
    tick();
    chk("ab_grant", 32'(grant), 32'(4'b0010));
    tick();
    req = 4'b0100;
    tick();
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_noack", 32'(ack), 0);
    req = 4'b0110; out_ready = 1'b1; push(1);
    tick();
    chk("ab_again", 32'(grant), 32'(4'b0010));
    tick();
    chk("ab_ack", 32'(ack), 32'(4'b0010));
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a grant clears the outputs at once.
    req = 4'b0100; out_ready = 1'b0;
    tick();
    chk("ar_grant", 32'(grant), 32'(4'b0100));
    rst_n = 1'b0; req = 4'b0000;
    #1;
    chk("ar_clear", 32'({out_valid, grant}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

`ifdef MUX_ARB_LOCK_EN
    // Lock: three back-to-back transfers from requester 0, then requester 1 wins.
    lock = 1'b1; req = 4'b0011; out_ready = 1'b1;
    push(0); push(0); push(0); push(1);
    tick();
    chk("lk_grant", 32'(grant), 1);
    tick();
    chk("lk_ack1", 32'({ack, grant}), 32'(8'b0001_0001));
    tick();
    chk("lk_ack2", 32'({ack, grant}), 32'(8'b0001_0001));
    lock = 1'b0;
    tick();
    chk("lk_ack3", 32'({ack, grant}), 32'(8'b0001_0000));
    req = 4'b0010;
    tick();
    chk("lk_next", 32'(grant), 32'(4'b0010));
    tick();
    chk("lk_ack_r1", 32'(ack), 32'(4'b0010));
    req = 4'b0000;
    tick();
`endif

    tick();
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
